// File: rtl/adc_frame_source.sv
// ADC-rate pattern source (ramp / LFSR / impulse / constant) with frame tagging and a skid FIFO.
// Latency 1 cycle strobe-to-tvalid; ADC side never stalls, so pushes into a full FIFO are dropped and flagged.
module adc_frame_source #(
    parameter int          WIDTH      = 8,
    parameter int          FRAME_LEN  = 2048,
    parameter int          FIFO_DEPTH = 4,
    parameter logic [15:0] LFSR_SEED  = 16'hACE1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             sample_stb,
    input  logic [1:0]       mode,
    input  logic [WIDTH-1:0] const_val,
    output logic [WIDTH-1:0] m_axis_tdata,
    output logic             m_axis_tvalid,
    input  logic             m_axis_tready,
    output logic             m_axis_tlast,
    output logic [31:0]      frame_cnt,
    output logic             overflow
);
    localparam int IDX_W = $clog2(FRAME_LEN);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(FRAME_LEN - 1);
    localparam logic [PTR_W:0]   DEPTH_C  = (PTR_W + 1)'(FIFO_DEPTH);
    localparam logic [1:0] MODE_RAMP = 2'd0;
    localparam logic [1:0] MODE_LFSR = 2'd1;
    localparam logic [1:0] MODE_IMP  = 2'd2;

    logic [IDX_W-1:0] idx_q, idx_d;
    logic [WIDTH-1:0] ramp_q, ramp_d;
    logic [15:0]      lfsr_q, lfsr_d;
    logic [1:0]       amode_q, amode_d;
    logic [31:0]      frame_cnt_q, frame_cnt_d;
    logic             overflow_q, overflow_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]   count_q, count_d;
    logic [WIDTH:0]   mem_q [FIFO_DEPTH];

    logic             gen, pop, push, full, is_last;
    logic [1:0]       eff_mode;
    logic [WIDTH-1:0] sample;

    assign gen      = en & sample_stb;
    assign full     = (count_q == DEPTH_C);
    assign pop      = m_axis_tvalid & m_axis_tready;
    assign push     = gen & (~full | pop);
    assign is_last  = (idx_q == IDX_LAST);
    // The frame's first sample already uses the newly selected mode.
    assign eff_mode = (idx_q == '0) ? mode : amode_q;

    always_comb begin
        sample = const_val;
        case (eff_mode)
            MODE_RAMP: sample = ramp_q;
            MODE_LFSR: sample = lfsr_q[WIDTH-1:0];
            MODE_IMP:  sample = (idx_q == '0) ? {1'b0, {(WIDTH-1){1'b1}}} : '0;
            default:   sample = const_val;
        endcase
    end

    always_comb begin
        idx_d       = idx_q;
        ramp_d      = ramp_q;
        lfsr_d      = lfsr_q;
        amode_d     = amode_q;
        frame_cnt_d = frame_cnt_q;
        overflow_d  = overflow_q;
        if (gen) begin
            idx_d   = is_last ? '0 : idx_q + 1'b1;
            amode_d = eff_mode;
            if (eff_mode == MODE_RAMP) ramp_d = ramp_q + 1'b1;
            if (eff_mode == MODE_LFSR)
                lfsr_d = lfsr_q[0] ? ((lfsr_q >> 1) ^ 16'hB400) : (lfsr_q >> 1);
            if (is_last) frame_cnt_d = frame_cnt_q + 32'd1;
            if (!push)   overflow_d  = 1'b1;
        end
        wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
        count_d  = count_q + {{PTR_W{1'b0}}, push} - {{PTR_W{1'b0}}, pop};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            idx_q       <= '0;
            ramp_q      <= '0;
            lfsr_q      <= LFSR_SEED;
            amode_q     <= '0;
            frame_cnt_q <= '0;
            overflow_q  <= 1'b0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
        end else begin
            idx_q       <= idx_d;
            ramp_q      <= ramp_d;
            lfsr_q      <= lfsr_d;
            amode_q     <= amode_d;
            frame_cnt_q <= frame_cnt_d;
            overflow_q  <= overflow_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
        end
    end

    // Storage needs no reset: outputs are masked whenever the FIFO is empty.
    always_ff @(posedge clk) begin
        if (push && !rst) mem_q[wr_ptr_q] <= {is_last, sample};
    end

    assign m_axis_tvalid = (count_q != '0);
    assign m_axis_tdata  = m_axis_tvalid ? mem_q[rd_ptr_q][WIDTH-1:0] : '0;
    assign m_axis_tlast  = m_axis_tvalid & mem_q[rd_ptr_q][WIDTH];
    assign frame_cnt     = frame_cnt_q;
    assign overflow      = overflow_q;
endmodule
